vh_ext_shift_pipe: RTL

- Pipelined, parametrised shift/extend unit.
- Computes registered results under the language's width and signedness rules for four operations:
  - left shift
  - logical right shift
  - arithmetic right shift
  - replicate
- Serves as a golden sequential reference in the regression flow, comparing tool-synthesised netlists against simulation on corner cases: sign extension, unsigned shift amounts, and concat/replicate signedness loss.
- Valid/ready streaming interface with a full-pipeline stall.

---
 rtl/vh_ext_shift_pipe_if.sv | 28 ++
 rtl/vh_ext_shift_pipe.sv | 91 +++++++++
 2 files changed

// File: rtl/vh_ext_shift_pipe_if.sv
// rtl/vh_ext_shift_pipe_if.sv - operand/result stream bundle for vh_ext_shift_pipe
interface vh_ext_shift_pipe_if #(
  parameter int WIDTH_A = 2,
  parameter int WIDTH_B = 2,
  parameter int WIDTH_Y = 5,
  parameter int CNT_W   = 8
);
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH_A-1:0] in_a;
  logic [WIDTH_B-1:0] in_b;
  logic [1:0]         in_op;
  logic               in_signed;
  logic               out_valid;
  logic               out_ready;
  logic [WIDTH_Y-1:0] out_y;
  logic [CNT_W-1:0]   out_count;

  modport master (
    output in_valid, in_a, in_b, in_op, in_signed, out_ready,
    input  in_ready, out_valid, out_y, out_count
  );

  modport slave (
    input  in_valid, in_a, in_b, in_op, in_signed, out_ready,
    output in_ready, out_valid, out_y, out_count
  );
endinterface

// File: rtl/vh_ext_shift_pipe.sv
// rtl/vh_ext_shift_pipe.sv - pipelined shift/extend/replicate unit with full-pipeline stall
module vh_ext_shift_pipe #(
  parameter int WIDTH_A = 2,
  parameter int WIDTH_B = 2,
  parameter int WIDTH_Y = 5,
  parameter int REP     = 2,
  parameter int LATENCY = 2,
  parameter int CNT_W   = 8
) (
  input  logic               clk,
  input  logic               rst,
  vh_ext_shift_pipe_if.slave bus
);
  localparam int REP_W  = REP * WIDTH_A;
  localparam int WIDE_W = (REP_W > WIDTH_Y) ? REP_W : WIDTH_Y;

  logic                      w_advance;
  logic [WIDTH_Y-1:0]        w_ext;
  logic signed [WIDTH_Y-1:0] w_sra;
  logic [WIDE_W-1:0]         w_rep;
  logic [WIDTH_Y-1:0]        w_res;

  logic [LATENCY-1:0]        r_vld;
  logic [WIDTH_Y-1:0]        r_dat [LATENCY];
  logic [CNT_W-1:0]          r_count;

  // The whole pipe moves together; it only freezes when the output is held
  assign w_advance     = ~r_vld[LATENCY-1] | bus.out_ready;
  assign bus.in_ready  = w_advance;
  assign bus.out_valid = r_vld[LATENCY-1];
  assign bus.out_y     = r_dat[LATENCY-1];
  assign bus.out_count = r_count;

  // Arithmetic shift kept in a signed net so the fill comes from the extended MSB
  assign w_sra = $signed(w_ext) >>> bus.in_b;

  // Extend A, then pick the op; replicate works on raw A so its result is always unsigned
  always_comb begin
    w_ext = '0;
    w_rep = '0;
    w_res = '0;
    if (bus.in_signed) begin
      w_ext = WIDTH_Y'($signed(bus.in_a));
    end else begin
      w_ext = WIDTH_Y'(bus.in_a);
    end
    w_rep = WIDE_W'({REP{bus.in_a}});
    case (bus.in_op)
      2'd0: w_res = w_ext << bus.in_b;
      2'd1: w_res = w_ext >> bus.in_b;
      2'd2: begin
        if (bus.in_signed) begin
          w_res = w_sra;
        end else begin
          w_res = w_ext >> bus.in_b;
        end
      end
      default: w_res = w_rep[WIDTH_Y-1:0];
    endcase
  end

  // Stage registers; data moves only alongside a valid so out_y holds across bubbles
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vld <= '0;
      for (int i = 0; i < LATENCY; i++) begin
        r_dat[i] <= '0;
      end
    end else if (w_advance) begin
      r_vld[0] <= bus.in_valid;
      if (bus.in_valid) begin
        r_dat[0] <= w_res;
      end
      for (int i = 1; i < LATENCY; i++) begin
        r_vld[i] <= r_vld[i-1];
        if (r_vld[i-1]) begin
          r_dat[i] <= r_dat[i-1];
        end
      end
    end
  end

  // Count consumed results, wrapping naturally at the counter width
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (r_vld[LATENCY-1] && bus.out_ready) begin
      r_count <= r_count + 1'b1;
    end
  end
endmodule
